// File: rtl/psum_drain.sv
// Bottom-of-column psum collector: accumulates DEPTH psums over several passes,
// then requantises the final pass into a small skid FIFO on a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for start
// ACCUM   | accepting psums; last pass pushes requantised results to the FIFO
// DRAIN   | all psums taken, waiting for the FIFO to empty, then done
module psum_drain #(
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int OFM_WIDTH  = 8,
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   num_pass,
  input  logic [3:0]                   shift,
  input  logic                         relu_en,
  input  logic                         psum_valid,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic                         psum_ready,
  output logic                         ofm_valid,
  output logic [OFM_WIDTH-1:0]         ofm_data,
  input  logic                         ofm_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FA_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [FA_W:0] FIFO_FULL = (FA_W+1)'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0] OFM_MAX = (ACC_WIDTH+1)'((2**(OFM_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] OFM_MIN = (ACC_WIDTH+1)'(-(2**(OFM_WIDTH-1)));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]       r_num_pass, r_pass;
  logic [3:0]       r_shift;
  logic             r_relu;
  logic [IDX_W-1:0] r_idx;

  logic signed [ACC_WIDTH-1:0] r_buf [DEPTH];

  logic [OFM_WIDTH-1:0] r_fifo [FIFO_DEPTH];
  logic [FA_W-1:0]      r_wr_ptr, r_rd_ptr;
  logic [FA_W:0]        r_count;

  logic w_start, w_accept, w_last_pass, w_last_idx;
  logic w_push, w_pop, w_full, w_empty;

  logic signed [ACC_WIDTH-1:0] w_psum_ext, w_sum;
  logic signed [ACC_WIDTH:0]   w_add, w_round, w_rnd, w_shr, w_relu;
  logic [OFM_WIDTH-1:0]        w_q;

  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == FIFO_FULL);
  assign w_pop       = ofm_valid && ofm_ready;
  assign w_last_pass = (r_pass == r_num_pass - 8'd1);
  assign w_last_idx  = (r_idx == IDX_LAST);

  // Last pass may only accept when the result has somewhere to go this cycle.
  assign psum_ready = (r_state == S_ACCUM) && (!w_last_pass || !w_full || w_pop);
  assign w_accept   = psum_valid && psum_ready;
  assign w_push     = w_accept && w_last_pass;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start     = 1'b1;
          w_state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        busy = 1'b1;
        if (w_accept && w_last_pass && w_last_idx) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (w_empty) begin
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_pass <= 8'd0;
      r_pass     <= 8'd0;
      r_shift    <= 4'd0;
      r_relu     <= 1'b0;
      r_idx      <= '0;
    end else if (w_start) begin
      r_num_pass <= (num_pass == 8'd0) ? 8'd1 : num_pass;
      r_shift    <= shift;
      r_relu     <= relu_en;
      r_pass     <= 8'd0;
      r_idx      <= '0;
    end else if (w_accept) begin
      if (w_last_idx) begin
        r_idx  <= '0;
        r_pass <= r_pass + 8'd1;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign w_psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum_in[PSUM_WIDTH-1]}}, psum_in};

  always_comb begin
    w_add = {r_buf[r_idx][ACC_WIDTH-1], r_buf[r_idx]} + {w_psum_ext[ACC_WIDTH-1], w_psum_ext};
    if (r_pass == 8'd0)                             w_sum = w_psum_ext;
    else if (w_add[ACC_WIDTH] != w_add[ACC_WIDTH-1]) w_sum = w_add[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else                                             w_sum = w_add[ACC_WIDTH-1:0];
  end

  // The final pass never writes back; its sum only feeds the requantiser.
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_pass) r_buf[r_idx] <= w_sum;
  end

  assign w_round = (r_shift == 4'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (r_shift - 4'd1));
  assign w_rnd   = {w_sum[ACC_WIDTH-1], w_sum} + w_round;
  assign w_shr   = w_rnd >>> r_shift;

  always_comb begin
    w_relu = w_shr;
    if (r_relu && w_shr[ACC_WIDTH]) w_relu = '0;
    if (w_relu > OFM_MAX)      w_q = OFM_MAX[OFM_WIDTH-1:0];
    else if (w_relu < OFM_MIN) w_q = OFM_MIN[OFM_WIDTH-1:0];
    else                       w_q = w_relu[OFM_WIDTH-1:0];
  end

  // Head slot is never the write target while it is still unpopped, so ofm_data holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) r_fifo[k] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_q;
        r_wr_ptr         <= r_wr_ptr + FA_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FA_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FA_W+1)'(1);
        2'b01:   r_count <= r_count - (FA_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign ofm_valid = !w_empty;
  assign ofm_data  = r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_psum_drain.sv
// Randomised bench for psum_drain: a tile-level arithmetic model predicts every output
// word, FIFO occupancy, psum_ready, busy and done; a few directed tiles pin exact values.
module tb_psum_drain;
  localparam int D  = 16;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_pass = 8'd0;
  logic [3:0]  shift = 4'd0;
  logic        relu_en = 1'b0;
  logic        psum_valid = 1'b0;
  logic [15:0] psum_in = 16'd0;
  logic        psum_ready, ofm_valid, busy, done;
  logic [7:0]  ofm_data;
  logic        ofm_ready = 1'b0;

  always #5 clk = ~clk;

  psum_drain dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_pass(num_pass), .shift(shift),
    .relu_en(relu_en), .psum_valid(psum_valid), .psum_in(psum_in), .psum_ready(psum_ready),
    .ofm_valid(ofm_valid), .ofm_data(ofm_data), .ofm_ready(ofm_ready), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ps [8][D];
  int exp_q[$];
  int obs_q[$];
  int rdy_mode = 0;

  bit m_busy = 1'b0;
  int m_np = 1, m_acc = 0, m_push = 0, m_pop = 0, m_done_cnt = 0;
  bit prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  int  occ;
  bit  pop, in_last, exp_ready, exp_done;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat_acc(input longint v);
    if (v > 64'sd8388607)  return 64'sd8388607;
    if (v < -64'sd8388608) return -64'sd8388608;
    return v;
  endfunction

  function automatic int requant(input longint v, input int sh, input bit rl);
    longint r;
    r = v + ((sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0);
    r = r >>> sh;
    if (rl && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  function automatic int rnd_psum();
    logic [15:0] t;
    if ($urandom_range(1) == 0) return int'($urandom_range(400)) - 200;
    t = 16'($urandom);
    return int'($signed(t));
  endfunction

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       ofm_ready = 1'b1;
      1:       ofm_ready = ($urandom_range(3) != 0);
      default: ofm_ready = 1'b0;
    endcase
  end

  // Tile-level model: FIFO occupancy is simply last-pass accepts minus pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_psum_ready", psum_ready, 0);
      chk("rst_ofm_valid", ofm_valid, 0);
      chk("rst_ofm_data", ofm_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      m_busy = 0; m_acc = 0; m_push = 0; m_pop = 0; prev_hold = 0;
      exp_q.delete();
    end else begin
      occ = m_push - m_pop;
      pop = ofm_valid && ofm_ready;
      chk("ofm_valid", ofm_valid, occ > 0);
      chk("busy", busy, m_busy);
      if (prev_hold) chk("ofm_stable", ofm_data, prev_data);
      if (pop) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("ofm_data", $signed(ofm_data), exp_q.pop_front());
        obs_q.push_back(int'($signed(ofm_data)));
        m_pop++;
      end
      in_last   = m_busy && (m_acc >= (m_np - 1) * D) && (m_acc < m_np * D);
      exp_ready = m_busy && (m_acc < m_np * D) && (!in_last || occ < FD || pop);
      chk("psum_ready", psum_ready, exp_ready);
      exp_done  = m_busy && (m_acc == m_np * D) && (occ == 0);
      chk("done", done, exp_done);
      if (done) m_done_cnt++;
      if (psum_valid && psum_ready) begin
        if (in_last) m_push++;
        m_acc++;
      end
      if (exp_done) m_busy = 0;
      else if (start && !m_busy) begin
        m_busy = 1; m_acc = 0; m_push = 0; m_pop = 0;
        m_np = (num_pass == 8'd0) ? 1 : int'(num_pass);
      end
      prev_hold = ofm_valid && !ofm_ready;
      prev_data = ofm_data;
    end
  end

  task automatic run_tile(input int np, input int sh, input bit rl, input int pv,
                          input int abort_at, input bit mid_start);
    int np_eff = (np == 0) ? 1 : np;
    int acc = 0;
    int budget = 20000;
    longint s;
    for (int i = 0; i < D; i++) begin
      s = ps[0][i];
      for (int p = 1; p < np_eff; p++) s = sat_acc(s + ps[p][i]);
      exp_q.push_back(requant(s, sh, rl));
    end
    obs_q.delete();
    m_done_cnt = 0;
    @(posedge clk); #1;
    num_pass = 8'(np); shift = 4'(sh); relu_en = rl; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_pass = 8'($urandom); shift = 4'($urandom); relu_en = 1'($urandom);
    while (acc < np_eff * D && acc != abort_at && budget > 0) begin
      psum_valid = ($urandom_range(99) < pv);
      psum_in    = 16'(ps[acc / D][acc % D]);
      start      = mid_start && (acc == 5);
      if (start) begin num_pass = 8'd1; shift = 4'd9; relu_en = ~rl; end
      @(negedge clk);
      if (psum_valid && psum_ready) acc++;
      @(posedge clk); #1;
      budget--;
    end
    psum_valid = 1'b0;
    start      = 1'b0;
    if (budget == 0) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", acc, np_eff * D);
    end
    if (abort_at < 0) begin
      for (int k = 0; k < 3000 && m_busy; k++) @(posedge clk);
      #1;
      if (m_busy) begin
        n_checks++; n_fail++;
        $display("FAIL done_timeout: got busy 1 expected 0");
      end
      chk("done_count", m_done_cnt, 1);
      chk("exp_left", exp_q.size(), 0);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single pass identity
    rdy_mode = 0;
    for (int i = 0; i < D; i++) ps[0][i] = i;
    run_tile(1, 0, 0, 100, -1, 0);
    chk("t1_count", obs_q.size(), D);
    for (int i = 0; i < obs_q.size(); i++) chk("t1_value", obs_q[i], i);

    // Three passes of 100, shift 2
    for (int p = 0; p < 3; p++) for (int i = 0; i < D; i++) ps[p][i] = 100;
    run_tile(3, 2, 0, 100, -1, 0);
    chk("t2_count", obs_q.size(), D);
    for (int i = 0; i < obs_q.size(); i++) chk("t2_value", obs_q[i], 75);

    // Rounding, saturation, ReLU
    for (int i = 0; i < D; i++) ps[0][i] = rnd_psum();
    ps[0][0] = 6; ps[0][1] = 5;
    run_tile(1, 2, 0, 100, -1, 0);
    chk("t3_round6", obs_q[0], 2);
    chk("t3_round5", obs_q[1], 1);
    ps[0][0] = 1000; ps[0][1] = -1000;
    run_tile(1, 0, 0, 100, -1, 0);
    chk("t3_sat_hi", obs_q[0], 127);
    chk("t3_sat_lo", obs_q[1], -128);
    run_tile(0, 0, 1, 100, -1, 0);
    chk("t3_relu", obs_q[1], 0);

    // Backpressure during the last pass
    for (int p = 0; p < 2; p++) for (int i = 0; i < D; i++) ps[p][i] = rnd_psum();
    fork
      run_tile(2, 3, 0, 100, -1, 0);
      begin
        for (int k = 0; k < 2000 && m_acc < D + 2; k++) @(posedge clk);
        #1 rdy_mode = 2;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("stall_psum_ready", psum_ready, 0);
        chk("stall_ofm_valid", ofm_valid, 1);
        repeat (2) @(posedge clk);
        #1 rdy_mode = 0;
      end
    join
    chk("t4_count", obs_q.size(), D);

    // Reset in pass 1 at idx 7, then a clean tile
    rdy_mode = 1;
    for (int p = 0; p < 3; p++) for (int i = 0; i < D; i++) ps[p][i] = rnd_psum();
    run_tile(3, 1, 0, 70, D + 7, 0);
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_psum_ready", psum_ready, 0);
    chk("async_ofm_valid", ofm_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) ps[0][i] = i;
    run_tile(1, 0, 0, 80, -1, 0);
    chk("t5_count", obs_q.size(), D);
    for (int i = 0; i < obs_q.size(); i++) chk("t5_value", obs_q[i], i);

    // start during ACCUM is ignored
    for (int p = 0; p < 2; p++) for (int i = 0; i < D; i++) ps[p][i] = rnd_psum();
    run_tile(2, 4, 0, 60, -1, 1);

    // Random tiles
    for (int t = 0; t < 8; t++) begin
      for (int p = 0; p < 4; p++) for (int i = 0; i < D; i++) ps[p][i] = rnd_psum();
      run_tile($urandom_range(4), $urandom_range(15), 1'($urandom), $urandom_range(40, 100), -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
